// File: rtl/sim_ram_arb.sv
// sim_ram_arb: three-port arbitrated sim memory with a latency pipeline; SIM_RAM_RANGE_CHK_EN enables out-of-range errors
module sim_ram_arb #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int DEPTH = 4096,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int RD_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW/8-1:0] d_be_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic          d_err_o,
  output logic [DW-1:0] d_rdata_o,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic          if_err_o,
  output logic [DW-1:0] if_rdata_o
);
  localparam int NB = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int L = RD_LAT - 1;
  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] starve;
  logic force_if, any_gnt, s_we, s_err, lv;
  logic [1:0] s_port;
  logic [AW-1:0] s_addr, s_idx;
  logic [NB-1:0] s_be;
  logic [DW-1:0] s_wdata;
  logic [IW-1:0] s_wi;
  logic [RD_LAT-1:0] pv;
  logic [1:0] pp [RD_LAT];
  logic [DW-1:0] pd [RD_LAT];
`ifdef SIM_RAM_RANGE_CHK_EN
  logic [RD_LAT-1:0] pe;
`endif
  always_comb begin
    force_if = if_req_i && starve == CW'(STARVE_MAX);
    if_gnt_o = !rst && if_req_i && (force_if || (!dbg_req_i && !d_req_i));
    dbg_gnt_o = !rst && dbg_req_i && !force_if;
    d_gnt_o = !rst && d_req_i && !dbg_req_i && !force_if;
    any_gnt = dbg_gnt_o || d_gnt_o || if_gnt_o;
    s_port = dbg_gnt_o ? 2'd0 : d_gnt_o ? 2'd1 : 2'd2;
    s_addr = if_gnt_o ? if_addr_i : dbg_gnt_o ? dbg_addr_i : d_addr_i;
    s_we = dbg_gnt_o ? dbg_we_i : d_gnt_o ? d_we_i : 1'b0;
    s_be = dbg_gnt_o ? '1 : d_be_i;
    s_wdata = dbg_gnt_o ? dbg_wdata_i : d_wdata_i;
    s_idx = (s_addr - BASE_ADDR) >> OFF;
    s_wi = IW'(s_idx % AW'(DEPTH));
`ifdef SIM_RAM_RANGE_CHK_EN
    s_err = s_addr < BASE_ADDR || s_idx >= AW'(DEPTH);
`else
    s_err = 1'b0;
`endif
  end
  // fetch can never be denied past STARVE_MAX, so the counter cannot overflow
  always_ff @(posedge clk) begin
    starve <= (rst || !if_req_i || if_gnt_o) ? '0 : starve + 1'b1;
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pp[i] <= '0;
        pd[i] <= '0;
      end
`ifdef SIM_RAM_RANGE_CHK_EN
      pe <= '0;
`endif
    end else begin
      pv[0] <= any_gnt;
      pp[0] <= s_port;
      pd[0] <= (s_we || s_err) ? '0 : mem[s_wi];
`ifdef SIM_RAM_RANGE_CHK_EN
      pe[0] <= s_err;
`endif
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
        pd[i] <= pd[i-1];
`ifdef SIM_RAM_RANGE_CHK_EN
        pe[i] <= pe[i-1];
`endif
      end
    end
  end
  always_ff @(posedge clk)
    if (any_gnt && s_we && !s_err)
      for (int b = 0; b < NB; b++)
        if (s_be[b]) mem[s_wi][8*b +: 8] <= s_wdata[8*b +: 8];
  // gating with rst keeps a response due during reset from ever appearing
  always_comb begin
    lv = pv[L] && !rst;
    dbg_rvalid_o = lv && pp[L] == 2'd0;
    d_rvalid_o = lv && pp[L] == 2'd1;
    if_rvalid_o = lv && pp[L] == 2'd2;
    dbg_rdata_o = dbg_rvalid_o ? pd[L] : '0;
    d_rdata_o = d_rvalid_o ? pd[L] : '0;
    if_rdata_o = if_rvalid_o ? pd[L] : '0;
`ifdef SIM_RAM_RANGE_CHK_EN
    d_err_o = d_rvalid_o && pe[L];
    if_err_o = if_rvalid_o && pe[L];
`else
    d_err_o = 1'b0;
    if_err_o = 1'b0;
`endif
  end
endmodule

// File: tb/tb_sim_ram_arb.sv
// tb_sim_ram_arb: randomized bench for sim_ram_arb against a queue-based memory/arbitration model
module tb_sim_ram_arb;
  localparam int DW = 32, AW = 32, DEPTH = 4096, RD_LAT = 3, SM = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk, rst;
  logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0] d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  sim_ram_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_err_o(d_err), .d_rdata_o(d_rdata),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_err_o(if_err), .if_rdata_o(if_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {int due; int port; bit err; logic [31:0] data;} rsp_t;
  rsp_t q[$];
  logic [31:0] mm [int];
  int cyc, streak, n_cmp, n_bad;
  logic [2:0] eg, og;
  logic [100:0] er, orr;
  logic [31:0] last_d, last_if;
  function automatic void decode(input logic [31:0] a, output int wi, output bit err);
    logic [31:0] off;
    off = a - BASE;
    wi = int'((off >> 2) % 32'(DEPTH));
`ifdef SIM_RAM_RANGE_CHK_EN
    err = (a < BASE) || ((off >> 2) >= 32'(DEPTH));
`else
    err = 1'b0;
`endif
  endfunction
  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    return k == 0 ? BASE + 32'h4000 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3) :
           k == 1 ? BASE - 4 + $urandom_range(0, 3) :
                    BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
  endfunction
  // one clock: predict grant and response for this cycle, then apply the granted access to the model
  task automatic tick();
    bit fi, we, err;
    int wi, p;
    rsp_t r;
    logic [31:0] a, wd, rd;
    logic [3:0] be;
    @(negedge clk);
    fi = if_req && streak == SM;
    eg = rst ? 3'b000 : fi ? 3'b001 : dbg_req ? 3'b100 : d_req ? 3'b010 : if_req ? 3'b001 : 3'b000;
    og = {dbg_gnt, d_gnt, if_gnt};
    er = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (!rst) er = {r.port == 0, r.port == 1, r.port == 1 && r.err, r.port == 2, r.port == 2 && r.err,
                      r.port == 0 ? r.data : 32'h0, r.port == 1 ? r.data : 32'h0, r.port == 2 ? r.data : 32'h0};
    end
    orr = {dbg_rvalid, d_rvalid, d_err, if_rvalid, if_err, dbg_rdata, d_rdata, if_rdata};
    if (d_rvalid) last_d = d_rdata;
    if (if_rvalid) last_if = if_rdata;
    if (rst) begin
      q.delete();
      streak = 0;
    end else begin
      if (eg != 3'b000) begin
        p = eg[2] ? 0 : eg[1] ? 1 : 2;
        a = p == 0 ? dbg_addr : p == 1 ? d_addr : if_addr;
        we = p == 0 ? dbg_we : p == 1 ? d_we : 1'b0;
        be = p == 0 ? 4'hf : d_be;
        wd = p == 0 ? dbg_wdata : d_wdata;
        decode(a, wi, err);
        rd = (we || err) ? 32'h0 : mm[wi];
        q.push_back('{cyc + RD_LAT, p, err, rd});
        if (we && !err)
          for (int b = 0; b < 4; b++)
            if (be[b]) mm[wi][8*b +: 8] = wd[8*b +: 8];
      end
      streak = (if_req && !eg[0]) ? streak + 1 : 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic idle();
    dbg_req = 0; dbg_we = 0; d_req = 0; d_we = 0; d_be = 4'h0; if_req = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    dbg_req = 1; d_req = 1; if_req = 1;
    tick();
    tick();
    n_cmp++; if (og !== 3'b000) begin n_bad++; $display("FAIL reset_gnt got %b want 000", og); end
    n_cmp++; if (orr !== '0) begin n_bad++; $display("FAIL reset_rsp got %h want 0", orr); end
    rst = 0;
    idle();
    tick();
    n_cmp++; if (og !== 3'b000) begin n_bad++; $display("FAIL reset_idle_gnt got %b want 000", og); end
    n_cmp++; if (orr !== '0) begin n_bad++; $display("FAIL reset_idle_rsp got %h want 0", orr); end
  endtask
  task automatic test_load();
    for (int w = 0; w <= 64; w++) begin
      dbg_req = 1; dbg_we = 1; dbg_wdata = $urandom;
      dbg_addr = BASE + 4 * (w == 64 ? DEPTH - 1 : w);
      tick();
      n_cmp++; if (og !== eg) begin n_bad++; $display("FAIL load_gnt cyc=%0d got %b want %b", cyc, og, eg); end
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL load_rsp cyc=%0d got %h want %h", cyc, orr, er); end
    end
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL load_drain cyc=%0d got %h want %h", cyc, orr, er); end
    end
  endtask
  task automatic test_basic();
    dbg_req = 1; dbg_we = 1; dbg_addr = BASE + 32'h10; dbg_wdata = 32'hDEADBEEF;
    tick();
    n_cmp++; if (og !== 3'b100) begin n_bad++; $display("FAIL basic_dbg_gnt got %b want 100", og); end
    idle();
    if_req = 1; if_addr = BASE + 32'h10;
    tick();
    n_cmp++; if (og !== 3'b001) begin n_bad++; $display("FAIL basic_if_gnt got %b want 001", og); end
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL basic_rsp cyc=%0d got %h want %h", cyc, orr, er); end
    end
    n_cmp++; if (last_if !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_fetch_data got %h want deadbeef", last_if); end
  endtask
  task automatic test_byte_lanes();
    dbg_req = 1; dbg_we = 1; dbg_addr = BASE + 32'h20; dbg_wdata = 32'hAAAAAAAA;
    tick();
    idle();
    d_req = 1; d_we = 1; d_be = 4'b0101; d_addr = BASE + 32'h20; d_wdata = 32'h11223344;
    tick();
    n_cmp++; if (og !== 3'b010) begin n_bad++; $display("FAIL lanes_wr_gnt got %b want 010", og); end
    d_we = 0;
    tick();
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL lanes_rsp cyc=%0d got %h want %h", cyc, orr, er); end
    end
    n_cmp++; if (last_d !== 32'hAA22AA44) begin n_bad++; $display("FAIL lanes_data got %h want aa22aa44", last_d); end
  endtask
  task automatic test_starve();
    d_req = 1; d_we = 0; d_addr = BASE + 32'h20;
    if_req = 1; if_addr = BASE + 32'h10;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++; if (og !== ((i == 5 || i == 10) ? 3'b001 : 3'b010)) begin
        n_bad++; $display("FAIL starve_gnt cycle %0d got %b want %b", i, og, (i == 5 || i == 10) ? 3'b001 : 3'b010);
      end
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL starve_rsp cyc=%0d got %h want %h", cyc, orr, er); end
    end
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL starve_drain cyc=%0d got %h want %h", cyc, orr, er); end
    end
  endtask
  task automatic test_range();
    d_req = 1; d_we = 0; d_addr = BASE + 32'h4000;
    tick();
    d_we = 1; d_be = 4'hf; d_wdata = 32'h55555555;
    tick();
    idle();
    if_req = 1; if_addr = BASE;
    tick();
    if_addr = BASE - 2;
    tick();
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL range_rsp cyc=%0d got %h want %h", cyc, orr, er); end
    end
  endtask
  task automatic test_reset_flight();
    int seen;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if_req = 1; if_addr = BASE + 4 * (k + 1);
      tick();
      n_cmp++; if (og !== 3'b001) begin n_bad++; $display("FAIL flight_gnt %0d got %b want 001", k, og); end
    end
    idle();
    rst = 1;
    tick();
    seen += int'(if_rvalid);
    rst = 0;
    for (int i = 0; i <= RD_LAT + 1; i++) begin
      tick();
      seen += int'(if_rvalid);
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL flight_rsp cyc=%0d got %h want %h", cyc, orr, er); end
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flight_dropped got %0d pulses want 0", seen); end
    for (int k = 0; k < 3; k++) begin
      if_req = 1; if_addr = BASE + 4 * (k + 1);
      tick();
    end
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL flight_keep cyc=%0d got %h want %h", cyc, orr, er); end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1; dbg_we = 1'($urandom_range(0, 1)); dbg_addr = rand_addr(); dbg_wdata = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom); d_addr = rand_addr(); d_wdata = $urandom;
      end
      if (!if_req && $urandom_range(0, 1) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      tick();
      n_cmp++; if (og !== eg) begin n_bad++; $display("FAIL rand_gnt cyc=%0d got %b want %b", cyc, og, eg); end
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL rand_rsp cyc=%0d got %h want %h", cyc, orr, er); end
      if (eg[2]) dbg_req = 0;
      if (eg[1]) d_req = 0;
      if (eg[0]) if_req = 0;
    end
    idle();
    for (int i = 0; i <= RD_LAT; i++) begin
      tick();
      n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL rand_drain cyc=%0d got %h want %h", cyc, orr, er); end
    end
  endtask
  initial begin
    cyc = 0; streak = 0; n_cmp = 0; n_bad = 0;
    last_d = '0; last_if = '0;
    rst = 1;
    idle();
    dbg_addr = '0; dbg_wdata = '0; d_addr = '0; d_wdata = '0; if_addr = '0;
    test_reset();
    test_load();
    test_basic();
    test_byte_lanes();
    test_starve();
    test_range();
    test_reset_flight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
